// File: rtl/pwm_modulator_mc.sv
// Multi-channel PWM generator: shared prescaler, per-channel duty and phase,
// edge- or center-aligned counting, all settings double-buffered to period starts.
module pwm_modulator_mc #(
    parameter int CHANNELS    = 4,
    parameter int MOD_WIDTH   = 8,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          center_mode,
    input  logic [PRESC_WIDTH-1:0]        presc_div,
    input  logic [CHANNELS*MOD_WIDTH-1:0] setpoint,
    input  logic [CHANNELS*MOD_WIDTH-1:0] phase,
    output logic [CHANNELS-1:0]           pwm_out,
    output logic                          start_strobe,
    output logic                          busy
);

    typedef logic [MOD_WIDTH-1:0]   mod_t;
    typedef logic [PRESC_WIDTH-1:0] presc_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam mod_t   CNT_MAX = '1;
    localparam mod_t   CNT_ONE = mod_t'(1);
    localparam presc_t PC_ONE  = presc_t'(1);

    state_e          state_q, state_d;
    mod_t            cnt_q, cnt_d;
    presc_t          pc_q, pc_d;
    dir_e            dir_q, dir_d;
    logic            mode_sh_q, mode_sh_d;
    presc_t          div_sh_q, div_sh_d;
    mod_t            sp_sh_q [CHANNELS];
    mod_t            sp_sh_d [CHANNELS];
    mod_t            ph_sh_q [CHANNELS];
    mod_t            ph_sh_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic            strobe_q, strobe_d;

    logic                tick;
    logic                edge_wrap;
    logic                center_wrap;
    logic                load;
    logic [CHANNELS-1:0] pwm_raw;

    assign tick        = (pc_q == div_sh_q);
    assign edge_wrap   = (cnt_q == CNT_MAX);
    // In a two-count period (MOD_WIDTH=1) the top and the 1->0 step coincide.
    assign center_wrap = (cnt_q == CNT_ONE) && ((dir_q == DIR_DOWN) || (cnt_q == CNT_MAX));

    // Compare values seen by the output register: current counter vs. active shadows.
    always_comb begin
        pwm_raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (mode_sh_q) begin
                pwm_raw[i] = (cnt_q < sp_sh_q[i]);
            end else begin
                pwm_raw[i] = (mod_t'(cnt_q - ph_sh_q[i]) < sp_sh_q[i]);
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        dir_d     = dir_q;
        mode_sh_d = mode_sh_q;
        div_sh_d  = div_sh_q;
        sp_sh_d   = sp_sh_q;
        ph_sh_d   = ph_sh_q;
        pwm_d     = '0;
        strobe_d  = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ena) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pc_d    = '0;
                    dir_d   = DIR_UP;
                end else begin
                    pwm_d = pwm_raw;
                    pc_d  = tick ? '0 : pc_q + PC_ONE;
                    if (tick) begin
                        if (!mode_sh_q) begin
                            cnt_d = cnt_q + CNT_ONE;
                            load  = edge_wrap;
                        end else begin
                            if (dir_q == DIR_UP && cnt_q != CNT_MAX) begin
                                cnt_d = cnt_q + CNT_ONE;
                            end else begin
                                cnt_d = cnt_q - CNT_ONE;
                                dir_d = DIR_DOWN;
                            end
                            load = center_wrap;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Period start overrides any counter step decided above.
        if (load) begin
            cnt_d     = '0;
            pc_d      = '0;
            dir_d     = DIR_UP;
            strobe_d  = 1'b1;
            mode_sh_d = center_mode;
            div_sh_d  = presc_div;
            for (int i = 0; i < CHANNELS; i++) begin
                sp_sh_d[i] = setpoint[i*MOD_WIDTH +: MOD_WIDTH];
                ph_sh_d[i] = phase[i*MOD_WIDTH +: MOD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pc_q      <= '0;
            dir_q     <= DIR_UP;
            mode_sh_q <= 1'b0;
            div_sh_q  <= '0;
            // NOTE: the shadow arrays are a handful of flops, not a RAM, so they
            // are reset with everything else to keep the first compare defined.
            sp_sh_q   <= '{default: '0};
            ph_sh_q   <= '{default: '0};
            pwm_q     <= '0;
            strobe_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            dir_q     <= dir_d;
            mode_sh_q <= mode_sh_d;
            div_sh_q  <= div_sh_d;
            sp_sh_q   <= sp_sh_d;
            ph_sh_q   <= ph_sh_d;
            pwm_q     <= pwm_d;
            strobe_q  <= strobe_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign start_strobe = strobe_q;
    assign busy         = (state_q == ST_RUN);

endmodule

// File: tb/tb_pwm_modulator_mc.sv
// Self-checking bench for pwm_modulator_mc: directed scenarios plus randomized
// traffic against a period-position reference model.
module tb_pwm_modulator_mc;

    localparam int CH = 4;
    localparam int MW = 4;
    localparam int PW = 8;
    localparam int N  = 1 << MW;

    logic                clk = 1'b0;
    logic                rst;
    logic                ena;
    logic                center_mode;
    logic [PW-1:0]       presc_div;
    logic [CH*MW-1:0]    setpoint;
    logic [CH*MW-1:0]    phase;
    logic [CH-1:0]       pwm_out;
    logic                start_strobe;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;

    pwm_modulator_mc #(
        .CHANNELS   (CH),
        .MOD_WIDTH  (MW),
        .PRESC_WIDTH(PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .center_mode (center_mode),
        .presc_div   (presc_div),
        .setpoint    (setpoint),
        .phase       (phase),
        .pwm_out     (pwm_out),
        .start_strobe(start_strobe),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: position within the current period plus prescaler phase.
    bit          m_run;
    int          m_pos;
    int          m_sub;
    int          m_div;
    bit          m_mode;
    int          m_sp [CH];
    int          m_ph [CH];
    logic [CH-1:0] e_pwm;
    logic        e_strobe;
    logic        e_busy;

    int cyc = 0;
    int last_strobe = 0;
    int strobe_gap = 0;
    int hi_cnt [CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_sub  = 0;
        m_div  = 0;
        m_mode = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_sp[i] = 0;
            m_ph[i] = 0;
        end
        e_pwm    = '0;
        e_strobe = 1'b0;
        e_busy   = 1'b0;
    endtask

    task automatic load_shadows();
        for (int i = 0; i < CH; i++) begin
            m_sp[i] = int'(setpoint[i*MW +: MW]);
            m_ph[i] = int'(phase[i*MW +: MW]);
        end
        m_mode = center_mode;
        m_div  = int'(presc_div);
    endtask

    function automatic logic [CH-1:0] model_pwm();
        logic [CH-1:0] r;
        int c;
        r = '0;
        for (int i = 0; i < CH; i++) begin
            if (m_mode) begin
                c    = (m_pos < N) ? m_pos : 2 * (N - 1) - m_pos;
                r[i] = (c < m_sp[i]);
            end else begin
                r[i] = (((m_pos - m_ph[i] + N) % N) < m_sp[i]);
            end
        end
        return r;
    endfunction

    // Advances the model by the clock edge that will sample the current inputs.
    task automatic model_step();
        int plen;
        if (rst) begin
            model_reset();
            return;
        end
        e_strobe = 1'b0;
        if (!m_run) begin
            e_pwm = '0;
            if (ena) begin
                m_run = 1'b1;
                m_pos = 0;
                m_sub = 0;
                load_shadows();
                e_strobe = 1'b1;
            end
        end else if (!ena) begin
            m_run = 1'b0;
            m_pos = 0;
            m_sub = 0;
            e_pwm = '0;
        end else begin
            e_pwm = model_pwm();
            plen  = m_mode ? 2 * (N - 1) : N;
            if (m_sub == m_div) begin
                m_sub = 0;
                m_pos++;
                if (m_pos == plen) begin
                    m_pos = 0;
                    load_shadows();
                    e_strobe = 1'b1;
                end
            end else begin
                m_sub++;
            end
        end
        e_busy = m_run;
    endtask

    task automatic clk_step();
        model_step();
        @(negedge clk);
        check("pwm", 32'(pwm_out), 32'(e_pwm));
        check("strobe", 32'(start_strobe), 32'(e_strobe));
        check("busy", 32'(busy), 32'(e_busy));
        cyc++;
        for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm_out[i]);
        if (start_strobe) begin
            strobe_gap  = cyc - last_strobe;
            last_strobe = cyc;
        end
    endtask

    task automatic clear_hi();
        for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    endtask

    task automatic wait_strobe(input int budget);
        int n;
        n = 0;
        do begin
            clk_step();
            n++;
        end while (!start_strobe && n < budget);
        if (!start_strobe) check("strobe_timeout", 32'd0, 32'd1);
        clear_hi();
    endtask

    task automatic set_chan(input int i, input int sp, input int ph);
        setpoint[i*MW +: MW] = MW'(sp);
        phase[i*MW +: MW]    = MW'(ph);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rise [CH];
        int overlap;
        logic [CH-1:0] prev;
        logic first;

        rst = 1'b1; ena = 1'b0; center_mode = 1'b0; presc_div = '0;
        setpoint = '0; phase = '0;
        model_reset();
        clear_hi();
        #3;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_strobe", 32'(start_strobe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) clk_step();

        // Edge-aligned duty: 0, 4, 8, 15 out of 16.
        set_chan(0, 0, 0); set_chan(1, 4, 0); set_chan(2, 8, 0); set_chan(3, 15, 0);
        ena = 1'b1;
        clk_step();
        check("rise_strobe", 32'(start_strobe), 32'd1);
        check("rise_busy", 32'(busy), 32'd1);
        clear_hi();
        repeat (N) clk_step();
        check("edge_hi0", hi_cnt[0], 0);
        check("edge_hi1", hi_cnt[1], 4);
        check("edge_hi2", hi_cnt[2], 8);
        check("edge_hi3", hi_cnt[3], 15);
        wait_strobe(64);
        check("edge_gap", strobe_gap, 16);

        // Phase-staggered pulses.
        for (int i = 0; i < CH; i++) set_chan(i, 4, 4 * i);
        wait_strobe(64);
        for (int i = 0; i < CH; i++) rise[i] = -1;
        prev = pwm_out;
        overlap = 0;
        for (int k = 1; k <= N; k++) begin
            clk_step();
            for (int i = 0; i < CH; i++)
                if (pwm_out[i] && !prev[i] && rise[i] < 0) rise[i] = k;
            if ($countones(pwm_out) > 1) overlap++;
            prev = pwm_out;
        end
        check("phase_rise_delta", rise[1] - rise[0], 4);
        check("phase_overlap", overlap, 0);
        for (int i = 0; i < CH; i++) check("phase_hi", hi_cnt[i], 4);

        // Center-aligned, prescaler 2, sp=3.
        center_mode = 1'b1; presc_div = 8'd1;
        for (int i = 0; i < CH; i++) set_chan(i, 3, 0);
        wait_strobe(64);
        wait_strobe(200);
        check("center_gap", strobe_gap, 60);
        clk_step();
        first = pwm_out[0];
        repeat (59) clk_step();
        check("center_head", 32'(first), 32'd1);
        check("center_hi", hi_cnt[0], 10);

        // Shadow update mid-period.
        center_mode = 1'b0; presc_div = '0;
        for (int i = 0; i < CH; i++) set_chan(i, 4, 0);
        wait_strobe(200);
        repeat (8) clk_step();
        for (int i = 0; i < CH; i++) set_chan(i, 12, 0);
        repeat (8) clk_step();
        check("shadow_old_hi", hi_cnt[0], 4);
        check("shadow_strobe", 32'(start_strobe), 32'd1);
        clear_hi();
        repeat (N) clk_step();
        check("shadow_new_hi", hi_cnt[0], 12);

        // Drop enable mid-pulse, then restart.
        repeat (3) clk_step();
        ena = 1'b0;
        clk_step();
        check("drop_pwm", 32'(pwm_out), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_strobe", 32'(start_strobe), 32'd0);
        repeat (2) clk_step();
        ena = 1'b1;
        set_chan(0, 6, 0);
        clk_step();
        check("restart_strobe", 32'(start_strobe), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);

        // Asynchronous reset mid-period.
        repeat (5) clk_step();
        #2 rst = 1'b1;
        #1;
        check("arst_pwm", 32'(pwm_out), 32'd0);
        check("arst_strobe", 32'(start_strobe), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        model_reset();
        repeat (2) clk_step();
        rst = 1'b0;
        clk_step();
        check("post_rst_start", 32'(start_strobe), 32'd1);

        // Randomized traffic.
        repeat (3000) begin
            ena = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 9) == 0) begin
                center_mode = 1'($urandom_range(0, 1));
                presc_div   = PW'($urandom_range(0, 3));
                for (int i = 0; i < CH; i++)
                    set_chan(i, int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
            end
            clk_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
